// File: rtl/calc_arbiter.sv
// calc_arbiter: two-requester front end sharing one combinational ALU (CombCalc).
// A round-robin grant picks one requester per cycle, and a one-deep result
// register holds that requester's result until the consumer takes it. Each
// requester also has a sticky overflow flag.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/ready            requester N handshake (ready is combinational)
//   reqN_op/a/b                 requester N opcode and signed operands
//   res_valid/res_ready         result handshake
//   res_id, res_r, res_ovf      owner index, value and overflow of the held result
//   ovf_clr, ovf_flag           per-requester clear pulse and sticky overflow

// CombCalc: add/sub/abs with signed overflow detection.
// When op[2]=1 the operands swap roles. For example, 100 computes B+A and 11x computes abs(A).
module CombCalc #(
  parameter int W = 16
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         ovf
);

  logic [W-1:0] lhs_s;
  logic [W-1:0] rhs_s;
  logic [W-1:0] sum_s;
  logic [W-1:0] diff_s;
  logic [W-1:0] negRhs_s;

  assign lhs_s    = op[2] ? b : a;
  assign rhs_s    = op[2] ? a : b;
  assign sum_s    = lhs_s + rhs_s;
  assign diff_s   = lhs_s - rhs_s;
  assign negRhs_s = ~rhs_s + {{(W-1){1'b0}}, 1'b1};

  // Result and overflow selection by operation class.
  always_comb begin
    r   = {W{1'b0}};
    ovf = 1'b0;
    case (op[1:0])
      2'b00: begin
        r   = sum_s;
        ovf = (lhs_s[W-1] == rhs_s[W-1]) && (sum_s[W-1] != lhs_s[W-1]);
      end
      2'b01: begin
        r   = diff_s;
        ovf = (lhs_s[W-1] != rhs_s[W-1]) && (diff_s[W-1] != lhs_s[W-1]);
      end
      2'b10, 2'b11: begin
        // The negation of the most negative value is itself. The sign bit stays set, and that marks the overflow.
        if (rhs_s[W-1]) begin
          r   = negRhs_s;
          ovf = negRhs_s[W-1];
        end else begin
          r   = rhs_s;
          ovf = 1'b0;
        end
      end
      default: begin
        r   = {W{1'b0}};
        ovf = 1'b0;
      end
    endcase
  end

endmodule

module calc_arbiter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [W-1:0] res_r,
  output logic         res_ovf,
  input  logic [1:0]   ovf_clr,
  output logic [1:0]   ovf_flag
);

  logic         prio_r;
  logic         space_s;
  logic         grant0_s;
  logic         grant1_s;
  logic         accept_s;
  logic [2:0]   calcOp_s;
  logic [W-1:0] calcA_s;
  logic [W-1:0] calcB_s;
  logic [W-1:0] calcRes_s;
  logic         calcOvf_s;

  // Space exists when the result slot is empty or is being drained this cycle.
  assign space_s  = !res_valid || res_ready;
  assign grant0_s = req0_valid && (!req1_valid || (prio_r == 1'b0));
  assign grant1_s = req1_valid && (!req0_valid || (prio_r == 1'b1));

  assign req0_ready = grant0_s && space_s && !reset;
  assign req1_ready = grant1_s && space_s && !reset;
  assign accept_s   = req0_ready || req1_ready;

  // The grant drives the operand mux. Requester 1 is selected only when it holds the grant.
  assign calcOp_s = grant1_s ? req1_op : req0_op;
  assign calcA_s  = grant1_s ? req1_a  : req0_a;
  assign calcB_s  = grant1_s ? req1_b  : req0_b;

  CombCalc #(.W(W)) uCalc (
    .op  (calcOp_s),
    .a   (calcA_s),
    .b   (calcB_s),
    .r   (calcRes_s),
    .ovf (calcOvf_s)
  );

  // Result register, owner index and round-robin priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_r     <= {W{1'b0}};
      res_ovf   <= 1'b0;
      prio_r    <= 1'b0;
    end else if (accept_s) begin
      res_valid <= 1'b1;
      res_id    <= grant1_s;
      res_r     <= calcRes_s;
      res_ovf   <= calcOvf_s;
      prio_r    <= !grant1_s;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= res_valid;
    end
  end

  // Sticky per-requester overflow. A new overflow wins over a clear on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_flag <= 2'b00;
    end else begin
      if (req0_ready && calcOvf_s) begin
        ovf_flag[0] <= 1'b1;
      end else if (ovf_clr[0]) begin
        ovf_flag[0] <= 1'b0;
      end else begin
        ovf_flag[0] <= ovf_flag[0];
      end
      if (req1_ready && calcOvf_s) begin
        ovf_flag[1] <= 1'b1;
      end else if (ovf_clr[1]) begin
        ovf_flag[1] <= 1'b0;
      end else begin
        ovf_flag[1] <= ovf_flag[1];
      end
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter (W=16): a table of single-op vectors,
// hand-written multi-cycle sequences and randomized traffic. A spec-level
// reference model checks the design on every cycle.
module tb_calc_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = 3'd0, req1_op = 3'd0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         res_valid, res_id, res_ovf;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_r;
  logic [1:0]   ovf_clr = 2'b00;
  logic [1:0]   ovf_flag;

  always #5 clk = ~clk;

  calc_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_r(res_r), .res_ovf(res_ovf),
    .ovf_clr(ovf_clr), .ovf_flag(ovf_flag)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic uses plain integers. The result wraps to 16 bits, and overflow means the true value lies outside the signed 16-bit range.
  typedef struct packed { logic [15:0] r; logic ovf; } calc_t;

  function automatic calc_t refCalc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ai, bi, v;
    calc_t c;
    ai = $signed(a);
    bi = $signed(b);
    case (op)
      3'd0:       v = ai + bi;
      3'd1:       v = ai - bi;
      3'd2, 3'd3: v = (bi < 0) ? -bi : bi;
      3'd4:       v = bi + ai;
      3'd5:       v = bi - ai;
      default:    v = (ai < 0) ? -ai : ai;
    endcase
    c.r   = v[15:0];
    c.ovf = (v > 32767) || (v < -32768);
    return c;
  endfunction

  // Model state.
  bit          mValid = 0, mId = 0, mOvf = 0, mPrio = 0;
  logic [15:0] mR = 16'h0000;
  bit   [1:0]  mFlag = 2'b00;
  logic [1:0]  rdySeen;

  // One clock cycle. Inputs must already be set. The task checks ready before the edge, advances the model, and checks the registered outputs after the edge.
  task automatic cycle();
    bit space, g0, g1, sel;
    logic [1:0] expRdy;
    calc_t c;
    #1;
    space  = !mValid || res_ready;
    g0     = req0_valid && (!req1_valid || !mPrio);
    g1     = req1_valid && (!req0_valid || mPrio);
    expRdy = {g1 && space && !reset, g0 && space && !reset};
    rdySeen = {req1_ready, req0_ready};
    chk("ready", rdySeen, expRdy);
    sel = expRdy[1];
    c = sel ? refCalc(req1_op, req1_a, req1_b) : refCalc(req0_op, req0_a, req0_b);
    @(posedge clk);
    #1;
    if (reset) begin
      mValid = 0; mId = 0; mR = 16'h0000; mOvf = 0; mPrio = 0; mFlag = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (expRdy[i] && c.ovf) mFlag[i] = 1'b1;
        else if (ovf_clr[i])    mFlag[i] = 1'b0;
      end
      if (expRdy != 2'b00) begin
        mValid = 1; mId = sel; mR = c.r; mOvf = c.ovf; mPrio = !sel;
      end else if (mValid && res_ready) begin
        mValid = 0;
      end
    end
    chk("res_valid", res_valid, mValid);
    chk("res_id", res_id, mId);
    chk("res_r", res_r, mR);
    chk("res_ovf", res_ovf, mOvf);
    chk("ovf_flag", ovf_flag, mFlag);
  endtask

  task automatic setReq(input int idx, input logic v, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b);
    if (idx == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic [15:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expR;
    logic        expOvf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{3'b000, 16'h0005, 16'h0003, 16'h0008, 1'b0};
    tbl[1]  = '{3'b001, 16'h0002, 16'h0007, 16'hFFFB, 1'b0};
    tbl[2]  = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
    tbl[3]  = '{3'b010, 16'h1234, 16'h8000, 16'h8000, 1'b1};
    tbl[4]  = '{3'b110, 16'hFFF7, 16'h0000, 16'h0009, 1'b0};
    tbl[5]  = '{3'b111, 16'h0004, 16'h5555, 16'h0004, 1'b0};
    tbl[6]  = '{3'b011, 16'h0000, 16'hFFFF, 16'h0001, 1'b0};
    tbl[7]  = '{3'b100, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
    tbl[8]  = '{3'b101, 16'h0003, 16'h000A, 16'h0007, 1'b0};
    tbl[9]  = '{3'b101, 16'h7FFF, 16'h8000, 16'h0001, 1'b1};
    tbl[10] = '{3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1};

    // Reset held two cycles with both requesters valid.
    reset = 1'b1; res_ready = 1'b1;
    setReq(0, 1'b1, 3'b000, 16'd5, 16'd3);
    setReq(1, 1'b1, 3'b001, 16'd2, 16'd7);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_ready", rdySeen, 2'b00);
    end
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_flag", ovf_flag, 2'b00);
    reset = 1'b0;

    // Arbitration: grants alternate starting from requester 0.
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("arb_grant", rdySeen, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("arb_id", res_id, i % 2);
      chk("arb_r", res_r, (i % 2 == 0) ? 16'h0008 : 16'hFFFB);
    end

    // Table vectors on requester 0 alone.
    reset = 1'b1; setReq(1, 1'b0, 3'b000, 16'd0, 16'd0); cycle(); reset = 1'b0;
    foreach (tbl[i]) begin
      setReq(0, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      cycle();
      chk("tbl_r", res_r, tbl[i].expR);
      chk("tbl_ovf", res_ovf, tbl[i].expOvf);
      chk("tbl_id", res_id, 1'b0);
    end

    // Backpressure: the held result stays stable, then delivery and a new accept happen together.
    reset = 1'b1; cycle(); reset = 1'b0;
    res_ready = 1'b0;
    setReq(0, 1'b1, 3'b000, 16'd5, 16'd3);
    cycle();
    setReq(1, 1'b1, 3'b001, 16'd2, 16'd7);
    for (int i = 0; i < 4; i++) begin
      setReq(0, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      cycle();
      chk("bp_ready", rdySeen, 2'b00);
      chk("bp_r", res_r, 16'h0008);
      chk("bp_id", res_id, 1'b0);
      chk("bp_valid", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    cycle();
    chk("bp_accept", rdySeen, 2'b10);
    chk("bp_new_r", res_r, 16'hFFFB);
    chk("bp_new_valid", res_valid, 1'b1);

    // Overflow flag: a set on the same edge as a clear wins. A clear alone clears.
    setReq(0, 1'b0, 3'b000, 16'd0, 16'd0); setReq(1, 1'b0, 3'b000, 16'd0, 16'd0);
    ovf_clr = 2'b11; cycle(); ovf_clr = 2'b00;
    setReq(1, 1'b1, 3'b000, 16'h7FFF, 16'h0001);
    cycle();
    chk("ovf_r", res_r, 16'h8000);
    chk("ovf_bit", res_ovf, 1'b1);
    chk("ovf_flag_set", ovf_flag, 2'b10);
    ovf_clr = 2'b10;
    cycle();
    chk("ovf_set_wins", ovf_flag, 2'b10);
    setReq(1, 1'b0, 3'b000, 16'd0, 16'd0);
    cycle();
    chk("ovf_cleared", ovf_flag, 2'b00);
    ovf_clr = 2'b00;

    // Reset mid-op: the held result is discarded and prio returns to 0.
    reset = 1'b1; cycle(); reset = 1'b0;
    res_ready = 1'b0;
    setReq(0, 1'b1, 3'b000, 16'd1, 16'd1);
    cycle();
    reset = 1'b1;
    cycle();
    chk("mid_ready", rdySeen, 2'b00);
    chk("mid_valid", res_valid, 1'b0);
    reset = 1'b0; res_ready = 1'b1;
    setReq(1, 1'b1, 3'b000, 16'd9, 16'd9);
    cycle();
    chk("mid_prio", rdySeen, 2'b01);
    chk("mid_r", res_r, 16'h0002);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
      setReq(0, 1'($urandom), 3'($urandom_range(0, 7)), randOperand(), randOperand());
      setReq(1, 1'($urandom), 3'($urandom_range(0, 7)), randOperand(), randOperand());
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter W, default 16, operand/result width in bits (signed two's complement).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester i's operation is accepted this cycle.
REQ-006 req0_op / req1_op  input  3  opcode: 000 A+B, 001 A-B, 01x abs(B), 100 B+A, 101 B-A, 11x abs(A).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  W  signed operands.
REQ-008 res_valid  output  1  result register holds an undelivered result.
REQ-009 res_ready  input  1  consumer accepts the result this cycle.
REQ-010 res_id  output  1  requester index that owns the held result.
REQ-011 res_r  output  W  held signed result.
REQ-012 res_ovf  output  1  overflow flag of the held result.
REQ-013 ovf_clr  input  2  per-requester clear pulse for ovf_flag.
REQ-014 ovf_flag  output  2  per-requester sticky overflow.

Function
REQ-015 The block SHALL instantiate exactly one CombCalc #(W) and share it between both requesters through an operand mux driven by the grant.
REQ-016 space = !res_valid | res_ready; no operation is accepted when space=0.
REQ-017 Grant: g0 = req0_valid & (!req1_valid | prio==0); g1 = req1_valid & (!req0_valid | prio==1); at most one grant per cycle.
REQ-018 reqi_ready = gi & space & !reset, combinational; it does not depend on reqi_ready of the other port.
REQ-019 Accept (reqi_valid & reqi_ready) at edge N: res_r/res_ovf capture the CombCalc outputs for requester i's op/a/b, res_id<=i, res_valid<=1; result visible in cycle N+1 (latency 1).
REQ-020 On accept, prio SHALL toggle to the non-granted index (round-robin); with only one requester valid, prio still moves to the other index.
REQ-021 prio holds when no accept occurs.
REQ-022 Delivery (res_valid & res_ready) with no accept in the same cycle: res_valid<=0; res_r/res_id/res_ovf hold their last values.
REQ-023 Simultaneous delivery and accept: new result replaces old in one edge, res_valid stays 1 (full throughput, one op per cycle).
REQ-024 While res_valid=1 and res_ready=0, res_r, res_id, res_ovf SHALL remain stable.
REQ-025 Arithmetic: results wrap modulo 2^W; res_ovf = CombCalc ovf, including abs of the most negative value (R = 0x8000 for W=16, ovf=1).
REQ-026 ovf_flag[i] sets on the accept edge of a requester-i op whose ovf=1; clears on ovf_clr[i]=1; simultaneous set and clear -> set wins.
REQ-027 Requester inputs may change freely while reqi_ready=0; only values on the accept edge are used.
REQ-028 No starvation: with both requesters continuously valid and res_ready=1, grants strictly alternate.

Reset
REQ-029 reset=1 SHALL force res_valid=0, res_id=0, res_r=0, res_ovf=0, prio=0, ovf_flag=00 on the next edge, overriding any simultaneous accept or delivery.
REQ-030 During reset, req0_ready = req1_ready = 0; a result held when reset asserts is discarded, not delivered.

Verification
REQ-031 Reset: assert reset 2 cycles with both req valid -> ready=00, res_valid=0, ovf_flag=00, prio=0 after release.
REQ-032 Arbitration: both valid, res_ready=1, req0 {000,5,3}, req1 {001,2,7} -> cycle+1 res_r=8 id=0; cycle+2 res_r=-5 (0xFFFB) id=1; grants alternate 0,1,0,1.
REQ-033 Backpressure: res_valid=1, res_ready=0 for 4 cycles -> both ready=0, res_r/res_id/res_ovf unchanged; res_ready=1 -> delivery and new accept in the same cycle.
REQ-034 Overflow: req1 {000,0x7FFF,1} -> res_r=0x8000, res_ovf=1, ovf_flag=10; then ovf_clr=10 on the same edge as a new req1 overflow -> ovf_flag stays 10; ovf_clr=10 alone -> 00.
REQ-035 Abs: req0 {010,x,0x8000} -> res_r=0x8000, res_ovf=1; req0 {110,-9,x} -> res_r=9, res_ovf=0; req0 {111,4,x} -> res_r=4.
REQ-036 Reset mid-op: reset on the accept edge of req0 {000,1,1} -> res_valid=0 next cycle, no result delivered, prio=0.
